// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / core reset fabric.
// The sequencer takes the master side; the PLL/core environment takes the slave side.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked,
    output pll_rst,
    output core_rst,
    output ready,
    output fault,
    output retry_cnt,
    output loss_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  core_rst,
    input  ready,
    input  fault,
    input  retry_cnt,
    input  loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Reset/lock sequencer for the core PLL, clocked by the PLL reference clock.
// Pulses the PLL reset, waits for a stable synchronized lock, then releases core reset.
// Lock loss in RUN restarts the sequence; too many lock timeouts latch a terminal fault.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYC = 32,
  parameter int unsigned LOCK_TMO_CYC = 65536,
  parameter int unsigned STABLE_CYC   = 1024,
  parameter int unsigned MAX_RETRY    = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned MaxAB  = (RST_HOLD_CYC > LOCK_TMO_CYC) ? RST_HOLD_CYC : LOCK_TMO_CYC;
  localparam int unsigned MaxCyc = (MaxAB > STABLE_CYC) ? MaxAB : STABLE_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  // Terminal counts: a state that lasts N cycles leaves when the counter shows N-1.
  localparam logic [CntW-1:0] HoldLast   = CntW'(RST_HOLD_CYC - 1);
  localparam logic [CntW-1:0] TmoLast    = CntW'(LOCK_TMO_CYC - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYC - 1);
  localparam logic [3:0]      RetryMax   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StHold,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            sync1_q, lk_q;
  logic            pll_rst_q, pll_rst_d;
  logic            core_rst_q, core_rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  // Next state, counters and output decode of the next state.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    cnt_d      = cnt_q;
    pll_rst_d  = 1'b1;
    core_rst_d = 1'b1;
    ready_d    = 1'b0;
    fault_d    = 1'b0;

    unique case (state_q)
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lk_q) begin
          state_d = StStable;
        end else if (cnt_q == TmoLast) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == RetryMax) ? StFault : StHold;
        end
      end
      StStable: begin
        if (!lk_q) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        if (!lk_q) begin
          state_d = StHold;
          if (loss_q != 8'hff) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StHold;
      end
    endcase

    // Counter only runs in timed states, so it cannot wrap while parked in RUN or FAULT.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StHold || state_q == StWaitLock || state_q == StStable) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_d)
      StHold: begin
        pll_rst_d  = 1'b1;
        core_rst_d = 1'b1;
      end
      StWaitLock, StStable: begin
        pll_rst_d  = 1'b0;
        core_rst_d = 1'b1;
      end
      StRun: begin
        pll_rst_d  = 1'b0;
        core_rst_d = 1'b0;
        ready_d    = 1'b1;
      end
      StFault: begin
        pll_rst_d  = 1'b1;
        core_rst_d = 1'b1;
        fault_d    = 1'b1;
      end
      default: begin
        pll_rst_d  = 1'b1;
        core_rst_d = 1'b1;
      end
    endcase
  end

  // State, counters, lock synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= StHold;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      sync1_q    <= 1'b0;
      lk_q       <= 1'b0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      sync1_q    <= bus.pll_locked;
      lk_q       <= sync1_q;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Edge numbers in comments count refclk rising edges after rst is released.
module tb_pll_reset_sequencer;

  logic refclk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_HOLD_CYC(4),
    .LOCK_TMO_CYC(20),
    .STABLE_CYC  (8),
    .MAX_RETRY   (3)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".pll_rst"}, 32'(bus.pll_rst), 1);
    check_eq({tag, ".core_rst"}, 32'(bus.core_rst), 1);
    check_eq({tag, ".ready"}, 32'(bus.ready), 0);
    check_eq({tag, ".fault"}, 32'(bus.fault), 0);
    check_eq({tag, ".retry"}, 32'(bus.retry_cnt), 0);
    check_eq({tag, ".loss"}, 32'(bus.loss_cnt), 0);
  endtask

  // Hold rst for 3 edges, check reset values, then release; next edge is edge 1.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(3);
    check_reset_vals(tag);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.pll_locked = 1'b1;

    // Reset values, then normal bring-up with lock present throughout.
    // lk=1 from edge 2, WAIT_LOCK at 4, STABLE at 5, RUN at 13.
    do_reset("rst1");
    step(3);
    check_eq("up.pll_rst_e3", 32'(bus.pll_rst), 1);
    step(1);
    check_eq("up.pll_rst_e4", 32'(bus.pll_rst), 0);
    check_eq("up.core_rst_e4", 32'(bus.core_rst), 1);
    step(8);
    check_eq("up.core_rst_e12", 32'(bus.core_rst), 1);
    check_eq("up.ready_e12", 32'(bus.ready), 0);
    step(1);
    check_eq("up.core_rst_e13", 32'(bus.core_rst), 0);
    check_eq("up.ready_e13", 32'(bus.ready), 1);
    check_eq("up.pll_rst_e13", 32'(bus.pll_rst), 0);
    check_eq("up.retry_e13", 32'(bus.retry_cnt), 0);

    // Loss in RUN: pin low from edge R+1, lk low at R+2, HOLD at R+3.
    // Relock: HOLD 4 edges, STABLE 8 edges, RUN 13 edges after HOLD entry.
    for (int i = 1; i <= 260; i++) begin
      bus.pll_locked = 1'b0;
      step(2);
      check_eq("loss.ready_before", 32'(bus.ready), 1);
      step(1);
      check_eq("loss.ready_after", 32'(bus.ready), 0);
      check_eq("loss.core_rst", 32'(bus.core_rst), 1);
      check_eq("loss.cnt", 32'(bus.loss_cnt), (i > 255) ? 255 : i);
      bus.pll_locked = 1'b1;
      step(13);
      check_eq("loss.relock_ready", 32'(bus.ready), 1);
    end
    check_eq("loss.final_cnt", 32'(bus.loss_cnt), 255);

    // Lock bounce during STABLE: pin low for edges 10..12, back at 13.
    // lk low at edges 11..13 (seen at 12..14), STABLE again at 15, RUN at 23.
    do_reset("rst2");
    step(9);
    check_eq("bounce.pll_rst_e9", 32'(bus.pll_rst), 0);
    check_eq("bounce.core_rst_e9", 32'(bus.core_rst), 1);
    bus.pll_locked = 1'b0;
    step(3);
    bus.pll_locked = 1'b1;
    step(1);
    check_eq("bounce.ready_e13", 32'(bus.ready), 0);
    step(9);
    check_eq("bounce.ready_e22", 32'(bus.ready), 0);
    step(1);
    check_eq("bounce.ready_e23", 32'(bus.ready), 1);
    check_eq("bounce.retry_e23", 32'(bus.retry_cnt), 0);

    // Timeout to fault: WAIT_LOCK 4..23, HOLD 24, WAIT 28, HOLD 48, WAIT 52, FAULT 72.
    bus.pll_locked = 1'b0;
    do_reset("rst3");
    step(4);
    check_eq("tmo.pll_rst_e4", 32'(bus.pll_rst), 0);
    step(19);
    check_eq("tmo.pll_rst_e23", 32'(bus.pll_rst), 0);
    check_eq("tmo.retry_e23", 32'(bus.retry_cnt), 0);
    step(1);
    check_eq("tmo.pll_rst_e24", 32'(bus.pll_rst), 1);
    check_eq("tmo.retry_e24", 32'(bus.retry_cnt), 1);
    step(24);
    check_eq("tmo.pll_rst_e48", 32'(bus.pll_rst), 1);
    check_eq("tmo.retry_e48", 32'(bus.retry_cnt), 2);
    step(23);
    check_eq("tmo.fault_e71", 32'(bus.fault), 0);
    check_eq("tmo.pll_rst_e71", 32'(bus.pll_rst), 0);
    step(1);
    check_eq("tmo.fault_e72", 32'(bus.fault), 1);
    check_eq("tmo.pll_rst_e72", 32'(bus.pll_rst), 1);
    check_eq("tmo.core_rst_e72", 32'(bus.core_rst), 1);
    check_eq("tmo.retry_e72", 32'(bus.retry_cnt), 3);
    // Lock arriving late must not leave FAULT.
    bus.pll_locked = 1'b1;
    step(100);
    check_eq("tmo.fault_held", 32'(bus.fault), 1);
    check_eq("tmo.ready_held", 32'(bus.ready), 0);
    check_eq("tmo.pll_rst_held", 32'(bus.pll_rst), 1);

    // Tie: pin high from edge 22 makes lk high at 23, seen at edge 24 = timeout edge.
    bus.pll_locked = 1'b0;
    do_reset("rst4");
    step(21);
    bus.pll_locked = 1'b1;
    step(2);
    check_eq("tie.pll_rst_e23", 32'(bus.pll_rst), 0);
    step(1);
    check_eq("tie.pll_rst_e24", 32'(bus.pll_rst), 0);
    check_eq("tie.retry_e24", 32'(bus.retry_cnt), 0);
    step(3);
    check_eq("tie.core_rst_e27", 32'(bus.core_rst), 1);
    // Reset in STABLE takes effect on the very next edge.
    rst = 1'b1;
    step(1);
    check_reset_vals("midrst");
    rst = 1'b0;
    step(13);
    check_eq("midrst.ready_e13", 32'(bus.ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
